// File: rtl/xm_pkg.sv
// Shared types for the stray-op sequencer and its operations unit.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package xm_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        PASS_B = 2'd0,
        SWPB   = 2'd1,
        SXT    = 2'd2,
        PASS_A = 2'd3
    } stray_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } seq_state_e;

    // Only PASS_B works without a register operand.
    function automatic logic needs_fetch(input stray_op_e op);
        return op != PASS_B;
    endfunction

endpackage

// File: rtl/stray_op_unit.sv
// Stray operations unit: pass-b, swap halves, sign-extend low half, pass-a.
// Latency: combinational.
// Backpressure: none; the result follows op/a/b directly.
// Ports: op (operation select), a (register operand), b (immediate operand), res (result).
module stray_op_unit
    import xm_pkg::*;
#(
    parameter int WORD = WORD_W
) (
    input  stray_op_e        op,
    input  logic [WORD-1:0]  a,
    input  logic [WORD-1:0]  b,
    output logic [WORD-1:0]  res
);

    localparam int HALF = WORD / 2;

    always_comb begin
        res = a;
        case (op)
            PASS_B:  res = b;
            SWPB:    res = {a[HALF-1:0], a[WORD-1:HALF]};
            SXT:     res = {{HALF{a[HALF-1]}}, a[HALF-1:0]};
            PASS_A:  res = a;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/stray_op_sequencer.sv
// Sequencer that reads a source register, runs the stray op unit and writes the result back.
// Latency: accept edge to write-back cycle is 1 cycle for PASS_B, 3 cycles for the other ops.
// Backpressure: cmd_ready is low while a command is in flight and whenever flush is high.
// Ports: cmd_* command handshake and fields, flush abort, rf_rd_* / rf_wr_* register-file
//        access, psw_* flag write, done pulse coincident with the register write.
module stray_op_sequencer
    import xm_pkg::*;
#(
    parameter int WORD     = WORD_W,
    parameter int REG_ADDR = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [REG_ADDR-1:0] cmd_src,
    input  logic [REG_ADDR-1:0] cmd_dst,
    input  logic [WORD-1:0]     cmd_imm,
    input  logic                cmd_psw,
    input  logic                flush,
    output logic                rf_rd_en,
    output logic [REG_ADDR-1:0] rf_rd_addr,
    input  logic [WORD-1:0]     rf_rd_data,
    output logic                rf_wr_en,
    output logic [REG_ADDR-1:0] rf_wr_addr,
    output logic [WORD-1:0]     rf_wr_data,
    output logic                psw_wr_en,
    output logic                psw_n,
    output logic                psw_z,
    output logic                done
);

    seq_state_e          state;
    logic                ready_q;
    stray_op_e           op_q;
    logic [REG_ADDR-1:0] dst_q;
    logic [WORD-1:0]     imm_q;
    logic                psw_q;
    logic [WORD-1:0]     res_q;
    logic                n_q;
    logic                z_q;

    logic                accept;
    logic [WORD-1:0]     unit_res;
    logic [WORD-1:0]     wb_res;
    logic                wb_n;
    logic                wb_z;

    // Operand a comes straight from the register file: read data is only
    // valid during EXEC, which is exactly when the result is registered.
    stray_op_unit #(.WORD(WORD)) u_unit (
        .op  (op_q),
        .a   (rf_rd_data),
        .b   (imm_q),
        .res (unit_res)
    );

    assign cmd_ready = ready_q & ~flush;
    assign accept    = cmd_valid & cmd_ready;

    // PASS_B skips EXEC, so its result never lands in res_q; it depends only
    // on the latched immediate and is therefore stable throughout WB.
    always_comb begin
        wb_res = res_q;
        wb_n   = n_q;
        wb_z   = z_q;
        if (op_q == PASS_B) begin
            wb_res = unit_res;
            wb_n   = unit_res[WORD-1];
            wb_z   = (unit_res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            op_q       <= PASS_B;
            dst_q      <= '0;
            imm_q      <= '0;
            psw_q      <= 1'b0;
            res_q      <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            psw_wr_en  <= 1'b0;
            psw_n      <= 1'b0;
            psw_z      <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Strobes and their qualifiers are single-cycle pulses.
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            psw_wr_en  <= 1'b0;
            psw_n      <= 1'b0;
            psw_z      <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        op_q    <= stray_op_e'(cmd_op);
                        dst_q   <= cmd_dst;
                        imm_q   <= cmd_imm;
                        psw_q   <= cmd_psw;
                        if (needs_fetch(stray_op_e'(cmd_op))) begin
                            state      <= FETCH;
                            rf_rd_en   <= 1'b1;
                            rf_rd_addr <= cmd_src;
                        end else begin
                            state <= WB;
                        end
                    end else begin
                        // Also brings ready up on the first edge after reset.
                        ready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        res_q <= unit_res;
                        n_q   <= unit_res[WORD-1];
                        z_q   <= (unit_res == '0);
                        state <= WB;
                    end
                end
                WB: begin
                    // flush is deliberately ignored: the write is committed.
                    rf_wr_en   <= 1'b1;
                    rf_wr_addr <= dst_q;
                    rf_wr_data <= wb_res;
                    done       <= 1'b1;
                    psw_wr_en  <= psw_q;
                    psw_n      <= psw_q & wb_n;
                    psw_z      <= psw_q & wb_z;
                    state      <= IDLE;
                    ready_q    <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stray_op_sequencer.sv
module tb_stray_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [15:0] cmd_imm;
    logic        cmd_psw;
    logic        flush;
    logic        rf_rd_en;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        psw_wr_en;
    logic        psw_n;
    logic        psw_z;
    logic        done;

    stray_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_imm    (cmd_imm),
        .cmd_psw    (cmd_psw),
        .flush      (flush),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .psw_wr_en  (psw_wr_en),
        .psw_n      (psw_n),
        .psw_z      (psw_z),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
        logic        psw;
        logic        n;
        logic        z;
        int          cyc;
    } wexp_t;

    typedef struct {
        logic [2:0] addr;
        int         cyc;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];

    logic [15:0] rf[8];     // register file seen by the DUT
    logic [15:0] mregs[8];  // reference copy, advanced by the model only

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] info);
        tests++;
        fails++;
        $display("FAIL %s: observed 0x%0h where nothing was expected", name, info);
    endtask

    // Reference semantics of the four stray ops on 16-bit words.
    function automatic logic [15:0] ref_op(input int op, input logic [15:0] a, input logic [15:0] imm);
        case (op)
            0:       return imm;
            1:       return ((a & 16'h00FF) << 8) | (a >> 8);
            2:       return (a & 16'h0080) != 0 ? (a | 16'hFF00) : (a & 16'h00FF);
            default: return a;
        endcase
    endfunction

    // Register file: read data valid the cycle after the strobe, noise otherwise.
    always @(posedge clk) begin
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : 16'($urandom);
    end

    // Monitor: pops the scoreboard whenever the DUT strobes a read or write.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_rd_en && rf_wr_en) flag("rd_wr_same_cycle", {rf_rd_addr, rf_wr_addr});
            if (done != rf_wr_en) flag("done_without_write", {done, rf_wr_en});
            if (rf_rd_en) begin
                if (rq.size() == 0) flag("unexpected_rd", rf_rd_addr);
                else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("rd_addr", rf_rd_addr, r.addr);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end
            if (rf_wr_en) begin
                if (wq.size() == 0) flag("unexpected_wr", {rf_wr_addr, rf_wr_data});
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", rf_wr_addr, e.dst);
                    chk("wr_data", rf_wr_data, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                    chk("done", done, 1);
                    chk("psw_wr_en", psw_wr_en, e.psw);
                    if (e.psw) begin
                        chk("psw_n", psw_n, e.n);
                        chk("psw_z", psw_z, e.z);
                    end
                end
            end
        end
    end

    // Issues one command (caller is in the low clock phase). flush_at selects the
    // cycle after acceptance (0,1,2) in which flush is pulsed, -1 for none.
    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [15:0] imm, input logic psw, input int flush_at,
                         input bit hold, output int waited);
        bit          acc;
        bit          abort;
        int          lat;
        logic [15:0] res;
        acc    = 0;
        waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        cmd_psw   = psw;
        while (!acc && waited < 50) begin
            #1;
            acc = cmd_ready;
            if (!acc) begin
                @(negedge clk);
                waited++;
            end
        end
        if (!acc) begin
            flag("accept_timeout", waited);
            cmd_valid = 1'b0;
            return;
        end
        lat   = (op == 2'd0) ? 1 : 3;
        abort = (op != 2'd0) && (flush_at == 0 || flush_at == 1);
        res   = ref_op(int'(op), mregs[src], imm);
        if (op != 2'd0) rq.push_back('{addr: src, cyc: cyc + 1});
        if (!abort) begin
            wq.push_back('{dst: dst, data: res, psw: psw, n: res[15], z: (res == 16'h0),
                           cyc: cyc + 1 + lat});
            mregs[dst] = res;
        end
        @(negedge clk);
        cmd_valid = hold && !abort;
        for (int k = 0; k < lat; k++) begin
            cmd_op  = 2'($urandom);
            cmd_src = 3'($urandom);
            cmd_dst = 3'($urandom);
            cmd_imm = 16'($urandom);
            cmd_psw = 1'($urandom);
            flush   = (k == flush_at);
            if (abort && k == flush_at + 1) begin
                #1;
                chk("ready_after_flush", cmd_ready, 1);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit prev_hold;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_src   = 3'd0;
        cmd_dst   = 3'd0;
        cmd_imm   = 16'h0;
        cmd_psw   = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf[i]    = 16'h1111 * 16'(i);
            mregs[i] = 16'h1111 * 16'(i);
        end
        rf[1] = 16'h12AB; mregs[1] = 16'h12AB;
        rf[2] = 16'h1280; mregs[2] = 16'h1280;
        rf[4] = 16'h8001; mregs[4] = 16'h8001;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
                              psw_wr_en, psw_n, psw_z, done}, 0);
        chk("reset_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_first_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge", cmd_ready, 1);
        @(negedge clk);

        // SXT R2=0x1280 -> R3 = 0xFF80, N=1.
        issue(2'd2, 3'd2, 3'd3, 16'h0, 1'b1, -1, 0, w);
        // SWPB R1 -> R1, no flags.
        issue(2'd1, 3'd1, 3'd1, 16'h0, 1'b0, -1, 0, w);
        @(negedge clk);
        // PASS_B imm 0 -> Z=1, no read.
        issue(2'd0, 3'd0, 3'd5, 16'h0000, 1'b1, -1, 0, w);
        @(negedge clk);
        // Back-to-back with cmd_valid held: SXT then PASS_A R4=0x8001.
        issue(2'd2, 3'd2, 3'd6, 16'h0, 1'b1, -1, 1, w);
        issue(2'd3, 3'd4, 3'd7, 16'h0, 1'b1, -1, 0, w);
        chk("b2b_accept_wait", w, 0);
        @(negedge clk);
        // flush during EXEC of SWPB, then a normal command.
        issue(2'd1, 3'd1, 3'd0, 16'h0, 1'b1, 1, 0, w);
        issue(2'd3, 3'd1, 3'd2, 16'h0, 1'b1, -1, 0, w);
        @(negedge clk);

        // flush in IDLE blocks acceptance.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_dst   = 3'd3;
        flush     = 1'b1;
        #1;
        chk("idle_flush_ready_0", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("idle_flush_ready_1", cmd_ready, 0);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in FETCH: command discarded.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_src   = 3'd4;
        cmd_dst   = 3'd5;
        cmd_psw   = 1'b1;
        #1;
        chk("pre_reset_ready", cmd_ready, 1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        chk("fetch_rd_en", rf_rd_en, 1);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
                                 psw_wr_en, psw_n, psw_z, done}, 0);
        chk("midreset_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("postreset_ready_high", cmd_ready, 1);
        @(negedge clk);

        // Randomized traffic.
        prev_hold = 0;
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            int         fa;
            int         r;
            bit         hold;
            op = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 7));
            fa = (r <= 2) ? r : -1;
            hold = ($urandom_range(0, 1) == 1) && !(op != 2'd0 && (fa == 0 || fa == 1)) && (n != 39);
            if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, 3'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), fa, hold, w);
            prev_hold = hold;
        end

        // Drain.
        for (int k = 0; k < 20 && (wq.size() != 0 || rq.size() != 0); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("wr_queue_drained", wq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
